// File: rtl/nrisc_pkg.sv
// Shared nRisc definitions: default datapath widths, the NOP opcode and the
// decode->execute stage-state enum with its occupancy mapping.
package nrisc_pkg;

  localparam int unsigned NRISC_OP_W   = 3;
  localparam int unsigned NRISC_REG_W  = 3;
  localparam int unsigned NRISC_DATA_W = 8;

  localparam logic [NRISC_OP_W-1:0] NRISC_NOP_OP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Number of held entries for a given stage state.
  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sign_zero_ext.sv
// Combinational sign/zero extender.
// Ports: din (IN_W raw value), is_signed (1 = replicate MSB, 0 = zero pad),
//        dout_c (OUT_W extended value). Requires OUT_W >= IN_W.
module sign_zero_ext #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  input  logic             is_signed,
  output logic [OUT_W-1:0] dout_c
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic fill;
  assign fill = is_signed & din[IN_W-1];

  generate
    if (PAD_W == 0) begin : g_same
      assign dout_c = din;
    end else begin : g_pad
      assign dout_c = {{PAD_W{fill}}, din};
    end
  endgenerate

endmodule

// File: rtl/id_ex_skid_stage.sv
// Decode->execute pipeline stage with a two-entry skid buffer.
// Extends register fields and immediate at capture, stores them in a main
// (output) register plus one skid register, and flushes on branch redirect.
// State updates on the falling clock edge; reset is asynchronous active-high.
// Ports: clock, reset; decode side in_valid/in_ready, operation, reg_a,
//        reg_b, immediate, imm_signed; flush; execute side ex_valid/ex_ready,
//        ex_op, ex_a, ex_b, ex_im; occupancy (0..2 entries held).
module id_ex_skid_stage
  import nrisc_pkg::*;
#(
  parameter int unsigned     OP_W   = NRISC_OP_W,
  parameter int unsigned     RA_W   = 3,
  parameter int unsigned     RB_W   = 2,
  parameter int unsigned     REG_W  = NRISC_REG_W,
  parameter int unsigned     IMM_W  = 8,
  parameter int unsigned     DATA_W = NRISC_DATA_W,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(NRISC_NOP_OP)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   operation,
  input  logic [RA_W-1:0]   reg_a,
  input  logic [RB_W-1:0]   reg_b,
  input  logic [IMM_W-1:0]  immediate,
  input  logic              imm_signed,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_W-1:0]  ex_a,
  output logic [REG_W-1:0]  ex_b,
  output logic [DATA_W-1:0] ex_im,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  a;
    logic [REG_W-1:0]  b;
    logic [DATA_W-1:0] im;
  } payload_t;

  // Contents of an unoccupied register: NOP with zeroed operands.
  localparam payload_t IDLE_WORD = '{op: NOP_OP, a: '0, b: '0, im: '0};

  stage_state_e state_q, state_d;
  payload_t     main_q, main_d;
  payload_t     skid_q, skid_d;
  payload_t     in_word;
  logic [DATA_W-1:0] imm_ext;
  logic         accept;
  logic         consume;

  // Immediate extension happens at capture so stored values are final.
  sign_zero_ext #(
    .IN_W  (IMM_W),
    .OUT_W (DATA_W)
  ) u_imm_ext (
    .din       (immediate),
    .is_signed (imm_signed),
    .dout_c    (imm_ext)
  );

  always_comb begin
    in_word    = IDLE_WORD;
    in_word.op = operation;
    in_word.a  = REG_W'(reg_a);
    in_word.b  = REG_W'(reg_b);
    in_word.im = imm_ext;
  end

  // in_ready/ex_valid are flops, so handshakes depend only on registered state.
  assign accept  = in_valid & in_ready;
  assign consume = ex_valid & ex_ready;

  // Next-state and payload steering; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_word;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = in_word;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_word;
        end else if (consume) begin
          state_d = EMPTY;
          main_d  = IDLE_WORD;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = IDLE_WORD;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = IDLE_WORD;
        skid_d  = IDLE_WORD;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = IDLE_WORD;
      skid_d  = IDLE_WORD;
    end
  end

  // State, payload and status flops; status is decoded from the next state.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      main_q    <= IDLE_WORD;
      skid_q    <= IDLE_WORD;
      in_ready  <= 1'b1;
      ex_valid  <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      in_ready  <= (state_d != FULL);
      ex_valid  <= (state_d != EMPTY);
      occupancy <= state_occupancy(state_d);
    end
  end

  assign ex_op = main_q.op;
  assign ex_a  = main_q.a;
  assign ex_b  = main_q.b;
  assign ex_im = main_q.im;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage (DATA_W = 16, NOP_OP = 3'd6).
// The driver pushes hand-computed expected payloads on each accept; a
// separate monitor compares and pops whenever execute consumes a beat.
module tb_id_ex_skid_stage;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned RA_W   = 3;
  localparam int unsigned RB_W   = 2;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned DATA_W = 16;
  localparam logic [OP_W-1:0] NOP = 3'd6;
  localparam int unsigned PAY_W  = OP_W + 2 * REG_W + DATA_W;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  ra;
    logic [1:0]  rb;
    logic [7:0]  imm;
    logic        sgn;
    logic [2:0]  ea;
    logic [2:0]  eb;
    logic [15:0] eim;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   operation;
  logic [RA_W-1:0]   reg_a;
  logic [RB_W-1:0]   reg_b;
  logic [IMM_W-1:0]  immediate;
  logic              imm_signed;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [OP_W-1:0]   ex_op;
  logic [REG_W-1:0]  ex_a;
  logic [REG_W-1:0]  ex_b;
  logic [DATA_W-1:0] ex_im;
  logic [1:0]        occupancy;

  logic [PAY_W-1:0]  sb_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;

  id_ex_skid_stage #(
    .OP_W   (OP_W),
    .RA_W   (RA_W),
    .RB_W   (RB_W),
    .REG_W  (REG_W),
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W),
    .NOP_OP (NOP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .immediate  (immediate),
    .imm_signed (imm_signed),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_op      (ex_op),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_im      (ex_im),
    .occupancy  (occupancy)
  );

  // Active edge is the falling edge at 10, 20, ...; rising edges at 5, 15, ...
  always #5 clock = ~clock;

  // Directed vectors with hand-computed extended results.
  function automatic vec_t vec(input int i);
    vec_t v;
    case (i)
      0:  v = '{3'd5, 3'd4, 2'd3, 8'hF0, 1'b1, 3'd4, 3'd3, 16'hFFF0};
      1:  v = '{3'd5, 3'd4, 2'd3, 8'hF0, 1'b0, 3'd4, 3'd3, 16'h00F0};
      2:  v = '{3'd1, 3'd7, 2'd0, 8'h7F, 1'b1, 3'd7, 3'd0, 16'h007F};
      3:  v = '{3'd2, 3'd1, 2'd1, 8'h80, 1'b1, 3'd1, 3'd1, 16'hFF80};
      4:  v = '{3'd3, 3'd2, 2'd2, 8'h80, 1'b0, 3'd2, 3'd2, 16'h0080};
      5:  v = '{3'd4, 3'd5, 2'd1, 8'hFF, 1'b1, 3'd5, 3'd1, 16'hFFFF};
      6:  v = '{3'd6, 3'd6, 2'd2, 8'h01, 1'b0, 3'd6, 3'd2, 16'h0001};
      7:  v = '{3'd7, 3'd0, 2'd3, 8'h00, 1'b1, 3'd0, 3'd3, 16'h0000};
      8:  v = '{3'd1, 3'd3, 2'd2, 8'hC3, 1'b1, 3'd3, 3'd2, 16'hFFC3};
      9:  v = '{3'd2, 3'd7, 2'd3, 8'h3C, 1'b0, 3'd7, 3'd3, 16'h003C};
      10: v = '{3'd3, 3'd1, 2'd0, 8'hAA, 1'b1, 3'd1, 3'd0, 16'hFFAA};
      default: v = '{3'd0, 3'd2, 2'd1, 8'h55, 1'b1, 3'd2, 3'd1, 16'h0055};
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    operation  = v.op;
    reg_a      = v.ra;
    reg_b      = v.rb;
    immediate  = v.imm;
    imm_signed = v.sgn;
  endtask

  // Present vector i until accepted; push its expected payload on acceptance.
  task automatic send(input int i);
    vec_t v;
    bit   done;
    v    = vec(i);
    done = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b1;
    flush    = 1'b0;
    drive_vec(v);
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (in_ready) begin
        sb_q.push_back({v.op, v.ea, v.eb, v.eim});
        @(negedge clock);
        done = 1'b1;
      end else begin
        @(posedge clock); #1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_ex_valid"},  32'(ex_valid),  32'd0);
    check({tag, "_ex_op"},     32'(ex_op),     32'(NOP));
    check({tag, "_ex_a"},      32'(ex_a),      32'd0);
    check({tag, "_ex_b"},      32'(ex_b),      32'd0);
    check({tag, "_ex_im"},     32'(ex_im),     32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  // Monitor: compare every presented beat with the queue head, pop on consume.
  always @(posedge clock) begin
    #3;
    if (!reset && ex_valid) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got 0x%0h expected no valid beat at %0t",
                 {ex_op, ex_a, ex_b, ex_im}, $time);
      end else begin
        if ({ex_op, ex_a, ex_b, ex_im} !== sb_q[0]) begin
          n_fail++;
          $display("FAIL sb_payload: got 0x%0h expected 0x%0h at %0t",
                   {ex_op, ex_a, ex_b, ex_im}, sb_q[0], $time);
        end
        if (ex_ready && !flush) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    ex_ready   = 1'b0;
    flush      = 1'b0;
    operation  = '0;
    reg_a      = '0;
    reg_b      = '0;
    immediate  = '0;
    imm_signed = 1'b0;

    // Reset state and release.
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst_held");
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_release");

    // Extension: signed then unsigned immediate, execute always ready.
    ex_ready = 1'b1;
    send(0);
    #1;
    check("ext_signed_im",  32'(ex_im),     32'h0000_FFF0);
    check("ext_signed_b",   32'(ex_b),      32'd3);
    check("ext_op",         32'(ex_op),     32'd5);
    check("ext_valid",      32'(ex_valid),  32'd1);
    send(1);
    #1;
    check("ext_unsigned_im", 32'(ex_im),     32'h0000_00F0);
    check("one_accept_consume_occ", 32'(occupancy), 32'd1);
    idle(1);
    @(negedge clock); #1;
    check("drain_occ", 32'(occupancy), 32'd0);

    // Fill both entries, then assert reset in the middle of a cycle.
    ex_ready = 1'b0;
    send(2);
    send(3);
    #1;
    check("fill_occ",      32'(occupancy), 32'd2);
    check("fill_in_ready", 32'(in_ready),  32'd0);
    idle(1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    sb_q.delete();
    reset = 1'b0;
    #1;
    check("rst_mid_release_ready", 32'(in_ready),  32'd1);
    check("rst_mid_release_occ",   32'(occupancy), 32'd0);

    // Streaming: 8 back-to-back beats with execute ready.
    ex_ready = 1'b1;
    for (int i = 4; i < 12; i++) begin
      send(i);
      #1;
      check("stream_occ", 32'(occupancy), 32'd1);
    end
    idle(1);
    @(negedge clock); #1;
    check("stream_drain_occ", 32'(occupancy), 32'd0);

    // Backpressure: execute stalls for three edges during a stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i);
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(posedge clock); #1;
          ex_ready = (c < 2 || c > 4);
          if (c == 2 || c == 4) begin
            @(negedge clock); #1;
            check("bp_occ_full",  32'(occupancy), 32'd2);
            check("bp_ready_low", 32'(in_ready),  32'd0);
          end
        end
        ex_ready = 1'b1;
      end
    join
    idle(3);
    @(negedge clock); #1;
    check("bp_drain_occ",   32'(occupancy),   32'd0);
    check("bp_queue_empty", 32'(sb_q.size()), 32'd0);

    // Flush with both entries held and a beat on the input.
    ex_ready = 1'b0;
    send(8);
    send(9);
    @(posedge clock); #1;
    in_valid = 1'b1;
    drive_vec(vec(10));
    flush = 1'b1;
    @(negedge clock); #1;
    sb_q.delete();
    check("flush_occ",   32'(occupancy), 32'd0);
    check("flush_valid", 32'(ex_valid),  32'd0);
    check("flush_op",    32'(ex_op),     32'(NOP));
    check("flush_im",    32'(ex_im),     32'd0);
    ex_ready = 1'b1;
    idle(3);
    #1;
    check("flush_no_ghost", 32'(ex_valid), 32'd0);

    // Simultaneous accept and consume in state ONE.
    send(11);
    send(0);
    #1;
    check("sim_occ", 32'(occupancy), 32'd1);
    check("sim_op",  32'(ex_op),     32'd5);
    check("sim_im",  32'(ex_im),     32'h0000_FFF0);
    idle(2);
    @(negedge clock); #1;
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);
    check("final_occ",         32'(occupancy),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
